// File: rtl/i2c_byte_master.sv
// I2C master byte engine on the local register bus: one CMD write runs an optional
// START, eight data bits plus ACK and an optional STOP, including SCL stretch handling.
module i2c_byte_master #(
   parameter int CLKDIV = 250
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [2:0]  Addr,
   output logic [15:0] DataRd,
   input  logic [15:0] DataWr,
   input  logic        En,
   input  logic        Rd,
   input  logic        Wr,
   output logic        SdaOut,
   input  logic        SdaIn,
   output logic        SclOut,
   input  logic        SclIn
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

   localparam logic [15:0] LP_LAST = 16'(CLKDIV - 1);

   state_t      r_state;
   logic [1:0]  r_quarter;
   logic [15:0] r_cnt;
   logic [3:0]  r_bit;
   logic [7:0]  r_txByte;
   logic        r_doStop;
   logic        r_read;
   logic        r_ackOut;
   logic [7:0]  r_rxByte;
   logic        r_rxAck;
   logic        r_ovr;

   logic        w_busy;
   logic        w_cmdWr;
   logic        w_statWr;
   logic        w_launch;
   logic        w_stretch;
   logic        w_qEnd;
   logic        w_sample;
   logic [7:0]  w_txByte;
   logic        w_read;
   logic        w_ackOut;
   state_t      w_nxtState;
   logic [1:0]  w_nxtQuarter;
   logic [3:0]  w_nxtBit;
   logic        w_nxtScl;
   logic        w_nxtSda;
   logic        w_unused;

   assign w_busy    = (r_state != S_IDLE);
   assign w_cmdWr   = Wr & En & (Addr == 3'd0);
   assign w_statWr  = Wr & En & (Addr == 3'd1);
   assign w_launch  = w_cmdWr & ~w_busy;
   assign w_stretch = w_busy && (r_quarter == 2'd1) && !SclIn;
   assign w_qEnd    = w_busy && !w_stretch && (r_cnt == LP_LAST);
   assign w_sample  = (r_state == S_BIT) && (r_quarter == 2'd2) && (r_cnt == LP_LAST);
   assign w_unused  = &{1'b0, Rd, DataWr[15:12]};

   // On launch the first bit must come from the command being written, not the old latch
   assign w_txByte = w_launch ? DataWr[7:0] : r_txByte;
   assign w_read   = w_launch ? DataWr[10]  : r_read;
   assign w_ackOut = w_launch ? DataWr[11]  : r_ackOut;

   always_comb begin
      w_nxtState   = r_state;
      w_nxtQuarter = r_quarter;
      w_nxtBit     = r_bit;
      if (w_launch) begin
         w_nxtState   = DataWr[8] ? S_START : S_BIT;
         w_nxtQuarter = 2'd0;
         w_nxtBit     = 4'd0;
      end else if (w_qEnd) begin
         w_nxtQuarter = r_quarter + 2'd1;
         if (r_quarter == 2'd3) begin
            case (r_state)
               S_START: begin
                  w_nxtState = S_BIT;
                  w_nxtBit   = 4'd0;
               end
               S_BIT: begin
                  if (r_bit == 4'd8) begin
                     w_nxtState = r_doStop ? S_STOP : S_IDLE;
                  end else begin
                     w_nxtBit = r_bit + 4'd1;
                  end
               end
               S_STOP:  w_nxtState = S_IDLE;
               default: w_nxtState = S_IDLE;
            endcase
         end
      end
   end

   // Line levels for the quarter being entered; only applied on a quarter boundary
   always_comb begin
      w_nxtScl = SclOut;
      w_nxtSda = SdaOut;
      case (w_nxtState)
         S_START: begin
            case (w_nxtQuarter)
               2'd0:    w_nxtSda = 1'b0;
               2'd1:    w_nxtScl = 1'b0;
               2'd2:    w_nxtSda = 1'b1;
               default: w_nxtScl = 1'b1;
            endcase
         end
         S_BIT: begin
            case (w_nxtQuarter)
               2'd0: begin
                  w_nxtScl = 1'b1;
                  if (w_read) begin
                     w_nxtSda = (w_nxtBit == 4'd8) ? ~w_ackOut : 1'b0;
                  end else begin
                     w_nxtSda = (w_nxtBit == 4'd8) ? 1'b0 : ~w_txByte[~w_nxtBit[2:0]];
                  end
               end
               2'd1:    w_nxtScl = 1'b0;
               default: w_nxtScl = 1'b0;
            endcase
         end
         S_STOP: begin
            case (w_nxtQuarter)
               2'd0: begin
                  w_nxtScl = 1'b1;
                  w_nxtSda = 1'b1;
               end
               2'd1:    w_nxtScl = 1'b0;
               2'd2:    w_nxtSda = 1'b0;
               default: w_nxtSda = 1'b0;
            endcase
         end
         default: begin
            // A byte ending without STOP parks the bus with SCL held low
            if (r_state == S_BIT) begin
               w_nxtScl = 1'b1;
               w_nxtSda = 1'b0;
            end else begin
               w_nxtScl = 1'b0;
               w_nxtSda = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_quarter <= 2'd0;
         r_cnt     <= 16'd0;
         r_bit     <= 4'd0;
         r_txByte  <= 8'h00;
         r_doStop  <= 1'b0;
         r_read    <= 1'b0;
         r_ackOut  <= 1'b0;
         r_rxByte  <= 8'h00;
         r_rxAck   <= 1'b0;
         r_ovr     <= 1'b0;
         SdaOut    <= 1'b0;
         SclOut    <= 1'b0;
      end else begin
         if (w_launch) begin
            r_txByte <= DataWr[7:0];
            r_doStop <= DataWr[9];
            r_read   <= DataWr[10];
            r_ackOut <= DataWr[11];
         end
         if (w_cmdWr && w_busy) begin
            r_ovr <= 1'b1;
         end else if (w_statWr && DataWr[2]) begin
            r_ovr <= 1'b0;
         end
         if (w_launch || w_qEnd) begin
            r_cnt     <= 16'd0;
            r_state   <= w_nxtState;
            r_quarter <= w_nxtQuarter;
            r_bit     <= w_nxtBit;
            SclOut    <= w_nxtScl;
            SdaOut    <= w_nxtSda;
         end else if (w_busy) begin
            r_cnt <= w_stretch ? 16'd0 : r_cnt + 16'd1;
         end
         if (w_sample) begin
            if (r_bit == 4'd8) begin
               r_rxAck <= SdaIn;
            end else begin
               r_rxByte <= {r_rxByte[6:0], SdaIn};
            end
         end
      end
   end

   always_comb begin
      DataRd = 16'h0000;
      case (Addr)
         3'd0:    DataRd = {8'h00, r_rxByte};
         3'd1:    DataRd = {r_rxByte, 5'b00000, r_ovr, r_rxAck, w_busy};
         default: DataRd = 16'h0000;
      endcase
   end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with an open-drain bus model and a scripted slave.
module tb_i2c_byte_master;
   localparam int LP_DIV     = 4;
   localparam int LP_Q       = LP_DIV;
   localparam int LP_SLOT    = 4 * LP_DIV;
   localparam int LP_STRETCH = 50;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [2:0]  Addr = 3'd0;
   logic [15:0] DataWr = 16'h0000;
   logic        En = 1'b0;
   logic        Rd = 1'b0;
   logic        Wr = 1'b0;
   logic [15:0] DataRd;
   logic        SdaOut;
   logic        SclOut;
   logic        slvSda = 1'b1;
   logic        sclHold = 1'b0;
   logic        w_sdaLine;
   logic        w_sclLine;
   int          passCount = 0;
   int          checkCount = 0;

   assign w_sdaLine = ~SdaOut & slvSda;
   assign w_sclLine = ~SclOut & ~sclHold;

   always #5 Clk = ~Clk;

   i2c_byte_master #(.CLKDIV(LP_DIV)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Addr   (Addr),
      .DataRd (DataRd),
      .DataWr (DataWr),
      .En     (En),
      .Rd     (Rd),
      .Wr     (Wr),
      .SdaOut (SdaOut),
      .SdaIn  (w_sdaLine),
      .SclOut (SclOut),
      .SclIn  (w_sclLine)
   );

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   // Issues one CMD, plays the slave slot by slot and checks line levels and BUSY length
   task automatic applyStimulus(input string tag, input logic [15:0] cmd, input logic [7:0] slvByte,
                                input logic slvAck, input int stretchSlot, input int ovrAt,
                                input int expBusy);
      int   offset;
      int   shift;
      int   rel;
      int   k;
      int   holdEnd;
      int   busyCycles;
      bit   stretched;
      bit   holding;
      logic expSda;
      offset     = cmd[8] ? LP_SLOT : 0;
      shift      = 0;
      holdEnd    = 0;
      busyCycles = 0;
      stretched  = 1'b0;
      holding    = 1'b0;
      Addr   = 3'd0;
      DataWr = cmd;
      En     = 1'b1;
      Wr     = 1'b1;
      @(posedge Clk); #1;
      for (int n = 0; n < 4000; n++) begin
         Wr   = 1'b0;
         En   = 1'b0;
         Addr = 3'd1;
         #1;
         if (DataRd[0] !== 1'b1) break;
         busyCycles++;
         if (holding && n == holdEnd) begin
            sclHold = 1'b0;
            holding = 1'b0;
         end
         rel = n - offset - shift;
         if (!holding) begin
            if (cmd[8] && rel == 2 * LP_Q - LP_SLOT) begin
               checkOutput($sformatf("%s start q2 sda", tag), {15'd0, SdaOut}, 16'd1);
               checkOutput($sformatf("%s start q2 scl", tag), {15'd0, SclOut}, 16'd0);
            end
            if (rel >= 0 && rel < 9 * LP_SLOT) begin
               k = rel / LP_SLOT;
               if (rel % LP_SLOT == 0) slvSda = (k < 8) ? slvByte[7 - k] : slvAck;
               if (rel % LP_SLOT == 1)
                  checkOutput($sformatf("%s slot%0d q0 scl", tag, k), {15'd0, SclOut}, 16'd1);
               if (rel % LP_SLOT == 2 * LP_Q) begin
                  if (cmd[10]) expSda = (k == 8) ? ~cmd[11] : 1'b0;
                  else         expSda = (k == 8) ? 1'b0 : ~cmd[7 - k];
                  checkOutput($sformatf("%s slot%0d q2 sda", tag, k), {15'd0, SdaOut}, {15'd0, expSda});
                  checkOutput($sformatf("%s slot%0d q2 scl", tag, k), {15'd0, SclOut}, 16'd0);
               end
               if (k == stretchSlot && rel % LP_SLOT == LP_Q && !stretched) begin
                  sclHold   = 1'b1;
                  holding   = 1'b1;
                  stretched = 1'b1;
                  holdEnd   = n + LP_STRETCH;
                  shift     = shift + LP_STRETCH;
               end
            end
            if (rel == 9 * LP_SLOT) slvSda = 1'b1;
            if (cmd[9] && rel == 9 * LP_SLOT + LP_Q) begin
               checkOutput($sformatf("%s stop q1 sda", tag), {15'd0, SdaOut}, 16'd1);
               checkOutput($sformatf("%s stop q1 scl", tag), {15'd0, SclOut}, 16'd0);
            end
            if (cmd[9] && rel == 9 * LP_SLOT + 2 * LP_Q) begin
               checkOutput($sformatf("%s stop q2 sda", tag), {15'd0, SdaOut}, 16'd0);
            end
         end
         if (n == ovrAt) begin
            Addr   = 3'd0;
            DataWr = 16'h0100;
            En     = 1'b1;
            Wr     = 1'b1;
         end
         @(posedge Clk); #1;
      end
      slvSda  = 1'b1;
      sclHold = 1'b0;
      checkOutput($sformatf("%s busy cycles", tag), 16'(busyCycles), 16'(expBusy));
   endtask

   task automatic readReg(input logic [2:0] a, output logic [15:0] val);
      Addr = a;
      #1;
      val = DataRd;
   endtask

   initial begin
      logic [15:0] rdVal;

      $display("[TB] reset");
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("reset sda", {15'd0, SdaOut}, 16'd0);
      checkOutput("reset scl", {15'd0, SclOut}, 16'd0);
      readReg(3'd1, rdVal);
      checkOutput("reset status", rdVal, 16'h0000);
      readReg(3'd0, rdVal);
      checkOutput("reset rxbyte", rdVal, 16'h0000);
      Reset = 1'b1;
      @(posedge Clk); #1;

      $display("[TB] write 0xA5 with START/STOP, slave ACK");
      applyStimulus("wrAck", 16'h03A5, 8'hFF, 1'b0, -1, -1, 176);
      readReg(3'd1, rdVal);
      checkOutput("wrAck status", rdVal, 16'hA500);
      readReg(3'd0, rdVal);
      checkOutput("wrAck rxbyte", rdVal, 16'h00A5);
      checkOutput("wrAck end sda", {15'd0, SdaOut}, 16'd0);
      checkOutput("wrAck end scl", {15'd0, SclOut}, 16'd0);

      $display("[TB] read 0x3C with NACK");
      applyStimulus("rdNack", 16'h0C00, 8'h3C, 1'b1, -1, -1, 144);
      readReg(3'd0, rdVal);
      checkOutput("rdNack rxbyte", rdVal, 16'h003C);
      readReg(3'd1, rdVal);
      checkOutput("rdNack status", rdVal, 16'h3C02);
      repeat (10) @(posedge Clk);
      #1;
      checkOutput("rdNack park scl", {15'd0, SclOut}, 16'd1);
      checkOutput("rdNack park sda", {15'd0, SdaOut}, 16'd0);

      $display("[TB] read 0x96 with ACK and stretch in slot 3");
      applyStimulus("stretch", 16'h0400, 8'h96, 1'b1, 3, -1, 144 + LP_STRETCH);
      readReg(3'd0, rdVal);
      checkOutput("stretch rxbyte", rdVal, 16'h0096);
      readReg(3'd1, rdVal);
      checkOutput("stretch status", rdVal, 16'h9600);

      $display("[TB] write 0x5A with STOP, slave NACK, overrun write");
      applyStimulus("nackOvr", 16'h025A, 8'hFF, 1'b1, -1, 40, 160);
      readReg(3'd1, rdVal);
      checkOutput("nackOvr status", rdVal, 16'h5A06);
      checkOutput("nackOvr end scl", {15'd0, SclOut}, 16'd0);
      Addr   = 3'd1;
      DataWr = 16'h0004;
      En     = 1'b1;
      Wr     = 1'b1;
      @(posedge Clk); #1;
      Wr = 1'b0;
      En = 1'b0;
      readReg(3'd1, rdVal);
      checkOutput("ovr cleared status", rdVal, 16'h5A02);

      $display("[TB] reset during slot 4");
      Addr   = 3'd0;
      DataWr = 16'h0181;
      En     = 1'b1;
      Wr     = 1'b1;
      @(posedge Clk); #1;
      Wr   = 1'b0;
      En   = 1'b0;
      Addr = 3'd1;
      repeat (81) @(posedge Clk);
      #1;
      checkOutput("midRst busy before", {15'd0, DataRd[0]}, 16'd1);
      checkOutput("midRst sda before", {15'd0, SdaOut}, 16'd1);
      checkOutput("midRst scl before", {15'd0, SclOut}, 16'd1);
      Reset = 1'b0;
      @(posedge Clk); #1;
      checkOutput("midRst sda", {15'd0, SdaOut}, 16'd0);
      checkOutput("midRst scl", {15'd0, SclOut}, 16'd0);
      readReg(3'd1, rdVal);
      checkOutput("midRst status", rdVal, 16'h0000);
      Reset = 1'b1;
      @(posedge Clk); #1;
      applyStimulus("afterRst", 16'h03C3, 8'hFF, 1'b0, -1, -1, 176);
      readReg(3'd1, rdVal);
      checkOutput("afterRst status", rdVal, 16'hC300);
      checkOutput("afterRst end sda", {15'd0, SdaOut}, 16'd0);
      checkOutput("afterRst end scl", {15'd0, SclOut}, 16'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
